led_step_ctrl: RTL and testbench

Controller that sequences the 8-bit LED pattern register on the board. It synchronizes the switch inputs, divides the board clock into a step tick, and runs a small state machine that loads, rotates, shifts or bounces the pattern. It replaces free-running divider bits and level-sensitive shift logic with one fully synchronous clock domain. It sits between the raw switch and button pins and the `led` pins.

---
 rtl/led_ctrl_pkg.sv | 20 ++
 rtl/led_step_ctrl_if.sv | 14 +
 rtl/led_pattern_reg.sv | 67 ++++++
 rtl/led_step_ctrl.sv | 131 +++++++++++++
 tb/tb_led_step_ctrl.sv | 241 ++++++++++++++++++++++++
 5 files changed

// File: rtl/led_ctrl_pkg.sv
// Shared types and constants for the LED step controller.
package led_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        MODE_ROT    = 2'b00,
        MODE_SHIFT  = 2'b01,
        MODE_BOUNCE = 2'b10,
        MODE_HOLD   = 2'b11
    } mode_t;

    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_RIGHT = 1'b1;

endpackage

// File: rtl/led_step_ctrl_if.sv
// Pin-level bundle between the switches/buttons, the LED pins and led_step_ctrl.
interface led_step_ctrl_if;
    logic [7:0] in;
    logic       load;
    logic       run;
    logic       dir;
    logic [1:0] mode;
    logic [7:0] led;
    logic       tick_alert;
    logic       busy;

    modport master (output in, load, run, dir, mode, input led, tick_alert, busy);
    modport slave  (input in, load, run, dir, mode, output led, tick_alert, busy);
endinterface

// File: rtl/led_pattern_reg.sv
// LED pattern register plus the bounce-direction flop; applies a load or one step.
module led_pattern_reg
    import led_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       n_rst,
    input  logic       load_en,
    input  logic       step_en,
    input  logic [7:0] load_val,
    input  logic       load_dir,
    input  logic       step_dir,
    input  mode_t      mode,
    output logic [7:0] led,
    output logic       step_zero
);
    logic       bounce_dir;
    logic       bounce_dir_next;
    logic [7:0] step_val;

    always_comb begin
        step_val        = led;
        bounce_dir_next = bounce_dir;
        case (mode)
            MODE_ROT:
                step_val = (step_dir == DIR_LEFT) ? {led[6:0], led[7]} : {led[0], led[7:1]};
            MODE_SHIFT:
                step_val = (step_dir == DIR_LEFT) ? {led[6:0], 1'b0} : {1'b0, led[7:1]};
            MODE_BOUNCE: begin
                // Pinned at both ends: nowhere to go, so the pattern and direction stay.
                if (!(led[7] && led[0])) begin
                    if (bounce_dir == DIR_LEFT) begin
                        if (led[7]) begin
                            bounce_dir_next = DIR_RIGHT;
                            step_val        = {1'b0, led[7:1]};
                        end else begin
                            step_val = {led[6:0], 1'b0};
                        end
                    end else begin
                        if (led[0]) begin
                            bounce_dir_next = DIR_LEFT;
                            step_val        = {led[6:0], 1'b0};
                        end else begin
                            step_val = {1'b0, led[7:1]};
                        end
                    end
                end
            end
            MODE_HOLD: step_val = led;
        endcase
    end

    assign step_zero = (step_val == 8'h00);

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            led        <= 8'h00;
            bounce_dir <= DIR_LEFT;
        end else if (load_en) begin
            led        <= load_val;
            bounce_dir <= load_dir;
        end else if (step_en) begin
            led        <= step_val;
            bounce_dir <= bounce_dir_next;
        end
    end

endmodule

// File: rtl/led_step_ctrl.sv
// LED step controller: input synchronizers, step prescaler and IDLE/RUN/PAUSE FSM.
module led_step_ctrl
    import led_ctrl_pkg::*;
#(
    parameter int unsigned TICK_DIV = 8388608
) (
    input  logic           clk,
    input  logic           n_rst,
    led_step_ctrl_if.slave bus
);
    localparam int CNT_W = $clog2(TICK_DIV);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TICK_DIV - 1);

    logic [2:0] load_sync;
    logic [2:0] sync_fill;
    logic [1:0] run_sync;
    logic [1:0] dir_sync;
    logic [1:0] mode_sync1;
    logic [1:0] mode_sync2;
    logic       load_pulse;

    logic       run_s;
    logic       dir_s;
    mode_t      mode_s;

    state_t           state, state_next;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic             load_en, step_en, tick;
    logic             step_zero;
    logic [7:0]       led_q;
    logic             busy_q, tick_q;

    // sync_fill marks when load_sync[2] holds a real post-reset sample, so a
    // load held high through reset cannot masquerade as a rising edge.
    // NOTE: flops use non-blocking assignments so every one samples pre-edge values.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            load_sync  <= '0;
            sync_fill  <= '0;
            run_sync   <= '0;
            dir_sync   <= '0;
            mode_sync1 <= '0;
            mode_sync2 <= '0;
            load_pulse <= 1'b0;
        end else begin
            load_sync  <= {load_sync[1:0], bus.load};
            sync_fill  <= {sync_fill[1:0], 1'b1};
            run_sync   <= {run_sync[0], bus.run};
            dir_sync   <= {dir_sync[0], bus.dir};
            mode_sync1 <= bus.mode;
            mode_sync2 <= mode_sync1;
            load_pulse <= load_sync[1] & ~load_sync[2] & sync_fill[2];
        end
    end

    assign run_s  = run_sync[1];
    assign dir_s  = dir_sync[1];
    assign mode_s = mode_t'(mode_sync2);

    // NOTE: every output of this block gets a default first, so no path infers a latch.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        load_en    = 1'b0;
        step_en    = 1'b0;
        tick       = 1'b0;
        if (load_pulse) begin
            load_en  = 1'b1;
            cnt_next = '0;
            if (bus.in == 8'h00)
                state_next = IDLE;
            else
                state_next = run_s ? RUN : PAUSE;
        end else begin
            case (state)
                IDLE: state_next = IDLE;
                RUN: begin
                    if (cnt == CNT_MAX) begin
                        // The step is always taken; a run drop only decides where we go next.
                        tick     = 1'b1;
                        step_en  = 1'b1;
                        cnt_next = '0;
                        if (step_zero)
                            state_next = IDLE;
                        else if (!run_s)
                            state_next = PAUSE;
                    end else if (!run_s) begin
                        state_next = PAUSE;
                    end else begin
                        cnt_next = cnt + CNT_W'(1);
                    end
                end
                PAUSE: if (run_s) state_next = RUN;
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state  <= IDLE;
            cnt    <= '0;
            busy_q <= 1'b0;
            tick_q <= 1'b0;
        end else begin
            state  <= state_next;
            cnt    <= cnt_next;
            busy_q <= (state_next == RUN);
            if (tick)
                tick_q <= ~tick_q;
        end
    end

    led_pattern_reg u_pattern (
        .clk       (clk),
        .n_rst     (n_rst),
        .load_en   (load_en),
        .step_en   (step_en),
        .load_val  (bus.in),
        .load_dir  (dir_s),
        .step_dir  (dir_s),
        .mode      (mode_s),
        .led       (led_q),
        .step_zero (step_zero)
    );

    assign bus.led        = led_q;
    assign bus.busy       = busy_q;
    assign bus.tick_alert = tick_q;

endmodule

// File: tb/tb_led_step_ctrl.sv
// Self-checking bench for led_step_ctrl: vector table, corner sequences, random run vs. model.
module tb_led_step_ctrl;

    logic clk = 1'b0;
    logic n_rst = 1'b1;
    int   checks = 0;
    int   failures = 0;
    bit   cmp_en = 1'b0;

    led_step_ctrl_if bus ();

    led_step_ctrl #(.TICK_DIV(4)) dut (
        .clk   (clk),
        .n_rst (n_rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %02h, expected %02h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic go(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Reference model: pins sampled per edge; run/dir/mode act two edges after
    // sampling, a load lands three edges after its rising sample.
    localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2;
    logic [7:0] m_led;
    int         m_st, m_cnt, m_v, n_edges;
    bit         m_bdir, m_tick;
    logic       load_h [0:4];
    logic       run_h  [0:4];
    logic       dir_h  [0:4];
    logic [1:0] mode_h [0:4];
    logic       run2, dir2, load_eff;
    logic [1:0] mode2;

    always @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            m_led = 8'h00; m_st = M_IDLE; m_cnt = 0; m_bdir = 0; m_tick = 0; n_edges = 0;
            for (int i = 0; i < 5; i++) begin
                load_h[i] = 0; run_h[i] = 0; dir_h[i] = 0; mode_h[i] = 2'b00;
            end
        end else begin
            for (int i = 4; i > 0; i--) begin
                load_h[i] = load_h[i-1]; run_h[i] = run_h[i-1];
                dir_h[i] = dir_h[i-1]; mode_h[i] = mode_h[i-1];
            end
            load_h[0] = bus.load; run_h[0] = bus.run; dir_h[0] = bus.dir; mode_h[0] = bus.mode;
            if (n_edges < 100) n_edges++;
            run2     = (n_edges >= 3) ? run_h[2] : 1'b0;
            dir2     = (n_edges >= 3) ? dir_h[2] : 1'b0;
            mode2    = (n_edges >= 3) ? mode_h[2] : 2'b00;
            load_eff = (n_edges >= 5) && load_h[3] && !load_h[4];
            if (load_eff) begin
                m_led = bus.in; m_cnt = 0; m_bdir = dir2;
                m_st = (bus.in == 8'h00) ? M_IDLE : (run2 ? M_RUN : M_PAUSE);
            end else if (m_st == M_RUN) begin
                if (m_cnt == 3) begin
                    m_cnt = 0;
                    m_tick = !m_tick;
                    m_v = int'(m_led);
                    case (mode2)
                        2'd0: m_v = dir2 ? (m_v / 2 + (m_v % 2) * 128) : ((m_v * 2) % 256 + m_v / 128);
                        2'd1: m_v = dir2 ? m_v / 2 : (m_v * 2) % 256;
                        2'd2: begin
                            if (m_v % 2 == 1 && m_v >= 128) begin
                                m_v = m_v;
                            end else if (!m_bdir) begin
                                if (m_v >= 128) begin m_bdir = 1; m_v = m_v / 2; end
                                else m_v = (m_v * 2) % 256;
                            end else begin
                                if (m_v % 2 == 1) begin m_bdir = 0; m_v = (m_v * 2) % 256; end
                                else m_v = m_v / 2;
                            end
                        end
                        default: m_v = m_v;
                    endcase
                    m_led = 8'(m_v);
                    if (m_led == 8'h00) m_st = M_IDLE;
                    else if (!run2) m_st = M_PAUSE;
                end else if (!run2) begin
                    m_st = M_PAUSE;
                end else begin
                    m_cnt++;
                end
            end else if (m_st == M_PAUSE && run2) begin
                m_st = M_RUN;
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            check("model_led", bus.led, m_led);
            check("model_busy", 8'(bus.busy), 8'(m_st == M_RUN));
            check("model_tick", 8'(bus.tick_alert), 8'(m_tick));
        end
    end

    typedef struct {
        logic [7:0]      in;
        logic [1:0]      mode;
        logic            dir;
        logic [3:0][7:0] exp;   // exp[0] at load, exp[1..3] after each step
        logic            busy;
    } vec_t;

    vec_t vecs [9];

    initial begin
        #200000;
        $display("FAIL timeout: bench did not reach its summary");
        $fatal(1, "timeout");
    end

    initial begin
        vecs[0] = '{8'h81, 2'b00, 1'b0, {8'h0C, 8'h06, 8'h03, 8'h81}, 1'b1};
        vecs[1] = '{8'h04, 2'b01, 1'b1, {8'h00, 8'h01, 8'h02, 8'h04}, 1'b0};
        vecs[2] = '{8'h40, 2'b10, 1'b0, {8'h20, 8'h40, 8'h80, 8'h40}, 1'b1};
        vecs[3] = '{8'h81, 2'b10, 1'b0, {8'h81, 8'h81, 8'h81, 8'h81}, 1'b1};
        vecs[4] = '{8'h01, 2'b00, 1'b1, {8'h20, 8'h40, 8'h80, 8'h01}, 1'b1};
        vecs[5] = '{8'h5A, 2'b11, 1'b0, {8'h5A, 8'h5A, 8'h5A, 8'h5A}, 1'b1};
        vecs[6] = '{8'h02, 2'b10, 1'b1, {8'h04, 8'h02, 8'h01, 8'h02}, 1'b1};
        vecs[7] = '{8'h80, 2'b01, 1'b0, {8'h00, 8'h00, 8'h00, 8'h80}, 1'b0};
        vecs[8] = '{8'h00, 2'b00, 1'b0, {8'h00, 8'h00, 8'h00, 8'h00}, 1'b0};

        bus.in = 8'h00; bus.load = 0; bus.run = 0; bus.dir = 0; bus.mode = 2'b00;

        // Reset, then 30 idle cycles with load low.
        #2 n_rst = 0;
        cmp_en = 1;
        repeat (3) @(posedge clk);
        #2 n_rst = 1;
        for (int i = 0; i < 30; i++) begin
            go(1);
            check("reset_led", bus.led, 8'h00);
            check("reset_busy", 8'(bus.busy), 8'h00);
            check("reset_tick", 8'(bus.tick_alert), 8'h00);
        end

        // Vector table: load, then three steps four edges apart.
        for (int v = 0; v < 9; v++) begin
            bus.in = vecs[v].in; bus.mode = vecs[v].mode; bus.dir = vecs[v].dir;
            bus.run = 1; bus.load = 1;
            go(1);
            bus.load = 0;
            go(3);
            check($sformatf("vec%0d_load", v), bus.led, vecs[v].exp[0]);
            for (int s = 1; s < 4; s++) begin
                go(4);
                check($sformatf("vec%0d_step%0d", v, s), bus.led, vecs[v].exp[s]);
            end
            check($sformatf("vec%0d_busy", v), 8'(bus.busy), 8'(vecs[v].busy));
        end

        // Pause mid-count, resume, then reload mid-count.
        bus.in = 8'h10; bus.mode = 2'b00; bus.dir = 0; bus.run = 1; bus.load = 1;
        go(1); bus.load = 0; go(3);
        check("pause_load", bus.led, 8'h10);
        go(4);
        check("pause_step1", bus.led, 8'h20);
        bus.run = 0;
        go(2);
        check("pause_busy_before", 8'(bus.busy), 8'h01);
        go(1);
        check("pause_busy", 8'(bus.busy), 8'h00);
        go(5);
        check("pause_frozen", bus.led, 8'h20);
        bus.run = 1;
        go(2);
        check("resume_busy_before", 8'(bus.busy), 8'h00);
        go(1);
        check("resume_busy", 8'(bus.busy), 8'h01);
        go(1);
        check("resume_no_step", bus.led, 8'h20);
        go(1);
        check("resume_step", bus.led, 8'h40);
        go(1);
        bus.load = 1;
        go(1); bus.load = 0; go(3);
        check("reload_led", bus.led, 8'h10);
        go(3);
        check("reload_no_early_step", bus.led, 8'h10);
        go(1);
        check("reload_step", bus.led, 8'h20);

        // Async reset mid-RUN with load held high through it.
        bus.load = 1;
        #2 n_rst = 0;
        #1;
        check("async_led", bus.led, 8'h00);
        check("async_busy", 8'(bus.busy), 8'h00);
        check("async_tick", 8'(bus.tick_alert), 8'h00);
        repeat (2) @(posedge clk);
        #2 n_rst = 1;
        for (int i = 0; i < 10; i++) begin
            go(1);
            check("held_load_led", bus.led, 8'h00);
            check("held_load_busy", 8'(bus.busy), 8'h00);
        end
        bus.load = 0;
        go(3);
        bus.in = 8'h33; bus.mode = 2'b00; bus.dir = 1; bus.run = 1; bus.load = 1;
        go(1); bus.load = 0; go(3);
        check("after_reset_load", bus.led, 8'h33);
        check("after_reset_busy", 8'(bus.busy), 8'h01);
        go(4);
        check("after_reset_rot_right", bus.led, 8'h99);

        // Randomized stretch checked against the model on every cycle.
        for (int c = 0; c < 1500; c++) begin
            if ($urandom_range(0, 9) == 0) bus.load = ~bus.load;
            if (!bus.load && $urandom_range(0, 3) == 0) begin
                case ($urandom_range(0, 7))
                    0:       bus.in = 8'h00;
                    1:       bus.in = 8'h81;
                    2, 3:    bus.in = 8'(1 << $urandom_range(0, 7));
                    default: bus.in = 8'($urandom_range(0, 255));
                endcase
            end
            if ($urandom_range(0, 11) == 0) bus.run = ~bus.run;
            if ($urandom_range(0, 7) == 0) bus.dir = ~bus.dir;
            if ($urandom_range(0, 19) == 0) bus.mode = 2'($urandom_range(0, 3));
            go(1);
        end

        go(2);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
